// File: rtl/edc_checker.sv
// ---------------------------------------------------------------------------
// edc_checker
//
// Read-side EDC checker for the main-memory path. It takes a 32-bit read word
// and its stored 8-bit check byte, recomputes the check bits and forms the
// syndrome. Single-bit errors are corrected (data or check bit), and
// double-bit errors are flagged as uncorrectable. The checker is a two-stage
// valid/ready pipeline. It also keeps saturating error counters and a log of
// the first error address.
//
// Optional feature: define EDC_SCRUB_EN to add a scrub request port. The first
// corrected error raises a request that carries the address, the corrected
// data and the regenerated check byte. The request is held until the cycle
// after it is acknowledged.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   input handshake (i_addr, i_data, i_check)
//   o_valid / i_ready   output handshake (o_data, o_ce, o_ue)
//   i_clr               clear counters, error log and interrupt
//   o_ce_cnt, o_ue_cnt  saturating correctable / uncorrectable counts
//   o_err_addr          address of the first logged error
//   o_err_vld           sticky flag, o_err_addr holds a logged address
//   o_irq               level interrupt, set when the logged error was a UE
//   o_scrub_*           scrub request (EDC_SCRUB_EN only)
//   i_scrub_ack         scrub acknowledge (EDC_SCRUB_EN only)
// ---------------------------------------------------------------------------
module edc_checker #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [AW-1:0]    i_addr,
  input  logic [31:0]      i_data,
  input  logic [7:0]       i_check,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_data,
  output logic             o_ce,
  output logic             o_ue,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_ce_cnt,
  output logic [CNT_W-1:0] o_ue_cnt,
  output logic [AW-1:0]    o_err_addr,
  output logic             o_err_vld,
  output logic             o_irq
`ifdef EDC_SCRUB_EN
  ,
  output logic             o_scrub_req,
  input  logic             i_scrub_ack,
  output logic [AW-1:0]    o_scrub_addr,
  output logic [31:0]      o_scrub_data,
  output logic [7:0]       o_scrub_check
`endif
);

  // Each check bit is the parity of the data bits selected by its mask.
  // Every data bit appears in exactly three masks, so every column has
  // odd weight. As a result, any double error yields an even-weight,
  // nonzero syndrome.
  localparam logic [31:0] MASK [0:7] = '{
    32'h0F0F1111, 32'hF0F02222, 32'h00FF4444, 32'hFF008888,
    32'h11110F0F, 32'h2222F0F0, 32'h444400FF, 32'h8888FF00
  };

  function automatic logic [7:0] calc_check(input logic [31:0] d);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) begin
      c[k] = ^(d & MASK[k]);
    end
    return c;
  endfunction

  // The syndrome produced by a flip of data bit j.
  function automatic logic [7:0] column(input logic [4:0] j);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) begin
      c[k] = MASK[k][j];
    end
    return c;
  endfunction

  logic          en;
  logic          out_xfer;

  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic [31:0]   s1_data;
  logic [7:0]    s1_syn;

  logic [AW-1:0] s2_addr;

  logic [31:0]   flip_mask;
  logic          data_hit;
  logic          check_hit;
  logic          fix_ce;
  logic          fix_ue;

  // The whole pipeline moves together. The pipeline freezes only when
  // the output holds a word that downstream has not taken.
  assign en       = !o_valid || i_ready;
  assign o_ready  = en;
  assign out_xfer = o_valid && i_ready;

  // Stage 1 captures the word and its syndrome. The payload is loaded
  // only for real words, so bubbles do not disturb the held values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_addr <= i_addr;
        s1_data <= i_data;
        s1_syn  <= calc_check(i_data) ^ i_check;
      end
    end
  end

  // Classify the syndrome. A match with a data column locates the bad
  // data bit. A single set bit means the check byte itself was hit, so
  // the data is already correct. Any other nonzero pattern is
  // uncorrectable, and the raw data passes through untouched, because
  // flip_mask stays zero in that case.
  always_comb begin
    flip_mask = '0;
    data_hit  = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (s1_syn == column(5'(j))) begin
        flip_mask[j] = 1'b1;
        data_hit     = 1'b1;
      end
    end
    check_hit = (s1_syn != 8'd0) && ((s1_syn & (s1_syn - 8'd1)) == 8'd0);
    fix_ce    = data_hit || check_hit;
    fix_ue    = (s1_syn != 8'd0) && !fix_ce;
  end

  // Stage 2 is the output register. The error flags are cleared for
  // bubbles, so a stale syndrome can never appear as an error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ce    <= 1'b0;
      o_ue    <= 1'b0;
      s2_addr <= '0;
    end else if (en) begin
      o_valid <= s1_valid;
      o_ce    <= s1_valid && fix_ce;
      o_ue    <= s1_valid && fix_ue;
      if (s1_valid) begin
        o_data  <= s1_data ^ flip_mask;
        s2_addr <= s1_addr;
      end
    end
  end

  // Counters and the first-error log update only on an output transfer.
  // A clear takes priority, so an error that transfers in the same cycle
  // as a clear is lost. The log address is kept through a clear, and it
  // becomes meaningful again only once o_err_vld is set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ce_cnt   <= '0;
      o_ue_cnt   <= '0;
      o_err_addr <= '0;
      o_err_vld  <= 1'b0;
      o_irq      <= 1'b0;
    end else if (i_clr) begin
      o_ce_cnt  <= '0;
      o_ue_cnt  <= '0;
      o_err_vld <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      if (out_xfer && o_ce && (o_ce_cnt != '1)) begin
        o_ce_cnt <= o_ce_cnt + CNT_W'(1);
      end
      if (out_xfer && o_ue && (o_ue_cnt != '1)) begin
        o_ue_cnt <= o_ue_cnt + CNT_W'(1);
      end
      if (out_xfer && (o_ce || o_ue) && !o_err_vld) begin
        o_err_addr <= s2_addr;
        o_err_vld  <= 1'b1;
        o_irq      <= o_ue;
      end
    end
  end

`ifdef EDC_SCRUB_EN
  // Only one scrub request is outstanding at a time. A corrected error
  // that arrives while a request is pending is not queued. The check
  // byte is regenerated from the corrected data, so the write-back is
  // clean even when the error was in the check byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_scrub_req   <= 1'b0;
      o_scrub_addr  <= '0;
      o_scrub_data  <= '0;
      o_scrub_check <= '0;
    end else if (o_scrub_req) begin
      if (i_scrub_ack) begin
        o_scrub_req <= 1'b0;
      end
    end else if (out_xfer && o_ce) begin
      o_scrub_req   <= 1'b1;
      o_scrub_addr  <= s2_addr;
      o_scrub_data  <= o_data;
      o_scrub_check <= calc_check(o_data);
    end
  end
`endif

endmodule

// File: doc/edc_checker.md
Name: edc_checker

Overview:
- Read-side counterpart of the EDC check-bit generator on the main-memory path.
- Takes a 32-bit read word plus its stored 8-bit check byte and recomputes the check bits.
- Forms the syndrome, corrects single-bit errors and flags double/multi-bit errors.
- Two-stage valid/ready pipeline between the memory read port and the read-data register feeding instruction decode; also keeps error counters and a first-error address log.

Parameters:
- AW, 32, width of i_addr / o_err_addr.
- CNT_W, 16, width of the saturating error counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  read word valid
- o_ready  out  1  checker can accept a word this cycle
- i_addr  in  AW  address of read word
- i_data  in  32  raw read data
- i_check  in  8  stored check byte
- o_valid  out  1  checked word valid
- i_ready  in  1  downstream accepts
- o_data  out  32  corrected data
- o_ce  out  1  correctable error on this word (qualified by o_valid)
- o_ue  out  1  uncorrectable error on this word (qualified by o_valid)
- i_clr  in  1  clear counters and error log
- o_ce_cnt  out  CNT_W  correctable-error count
- o_ue_cnt  out  CNT_W  uncorrectable-error count
- o_err_addr  out  AW  address of first logged error
- o_err_vld  out  1  sticky, o_err_addr holds a logged address
- o_irq  out  1  level interrupt, high while o_err_vld and the logged error was a UE

Behaviour:
- Clock i_clk; reset i_rst is synchronous and active-high.
- Reset values: all pipeline valids 0, o_valid 0, o_data 0, o_ce/o_ue 0, counters 0, o_err_addr 0, o_err_vld 0, o_irq 0.
- Pipeline enable: en = !o_valid | i_ready; o_ready = en. Stages advance only when en=1.
- Transfers happen on i_valid&o_ready (input) and o_valid&i_ready (output).
- Stage 1 registers addr, data and syndrome. Latency is 2 cycles from input transfer to o_valid with no back-pressure. Full throughput is 1 word/cycle.
- Check bits: gen[k] = ^(i_data & M[k]). Syndrome = gen ^ i_check.
- Masks M[k]: 7=0x8888FF00, 6=0x444400FF, 5=0x2222F0F0, 4=0x11110F0F, 3=0xFF008888, 2=0x00FF4444, 1=0xF0F02222, 0=0x0F0F1111.
- Column of data bit j = {k : M[k] bit j = 1}; every column has weight 3.
- Stage 2 classifies the syndrome s:
  - s==0: o_data = data, ce=0, ue=0.
  - s equals the column of bit j: o_data = data with bit j inverted, ce=1.
  - popcount(s)==1 (check-bit error): o_data = data unchanged, ce=1.
  - Any other s: o_data = raw data, ue=1.
- Counters update on an output transfer carrying ce (o_ce_cnt) or ue (o_ue_cnt). They saturate at all-ones and do not wrap.
- Error log:
  - On an output transfer with ce|ue while o_err_vld=0, capture the address, set o_err_vld, and set the irq-type bit if ue.
  - Later errors do not overwrite the log.
- i_clr zeroes both counters, o_err_vld and o_irq next cycle.
  - i_clr in the same cycle as an error transfer: clear wins, and that error is neither counted nor logged.
  - i_clr does not affect pipeline contents.
- Holding rules:
  - While o_valid&!i_ready, o_data/o_ce/o_ue stay stable and stage 1 holds.
  - i_valid is ignored when o_ready=0.
- Reset mid-operation drops all in-flight words; no output follows.

Optional Feature:
- Macro EDC_SCRUB_EN.
- When defined, add ports o_scrub_req (out 1), i_scrub_ack (in 1), o_scrub_addr (out AW), o_scrub_data (out 32), o_scrub_check (out 8).
- On an output transfer with ce=1 and no scrub pending:
  - latch addr, corrected data and its regenerated check byte;
  - raise o_scrub_req and hold it until the cycle after i_scrub_ack.
- Further CEs while pending are not queued; the counters still count them.
- When not defined, none of these ports or registers exist.

Test Plan:
- Clean word: data 0x12345678 with its correct check byte -> o_data 0x12345678, ce=0, ue=0, o_valid exactly 2 cycles after input.
- Bit 0 flipped: syndrome 0x51 -> bit 0 restored, ce=1, o_ce_cnt=1, o_err_vld=1 with logged addr, o_irq=0.
- Check-bit flip: bit 31 flipped (syndrome 0x8A) then check bit 3 flipped (syndrome 0x08) -> first corrected, second data unchanged. Both ce=1, o_ce_cnt=2, log keeps first addr.
- Two data bits (0 and 15) flipped: syndrome 0x51^0xA8=0xF9 -> ue=1, raw data passed, o_ue_cnt=1, o_irq=1 if first error. Then i_clr -> counts 0, o_irq=0.
- Back-pressure: stream 4 words with i_ready low for 3 cycles mid-stream -> no loss or duplication, outputs stable while stalled, o_ready=0 during stall.
- Saturation: force CNT_W=4, inject 20 CEs -> o_ce_cnt holds 15. With EDC_SCRUB_EN, the first CE raises o_scrub_req with correct addr/data/check, and it drops after i_scrub_ack.
